msg_sequencer: RTL
==================

// Module: msg_sequencer
//
// PURPOSE
//   Parametrised ROM-to-UART message sequencer. On a restart request it picks one of
//   2**SEL_W fixed-size message slots in a synchronous ROM and reads it byte by byte.
//   It hands each byte to the UART transmitter with a start/busy handshake and stops
//   at the terminator byte or at the end of the slot. Sits between a button/trigger
//   source, the message ROM and uart_tx.
//
// PARAMETERS
//   SEL_W    2      message-select width; 2**SEL_W slots
//   SLOT_W   4      log2 bytes per slot; slot length = 2**SLOT_W
//   ROM_LAT  1      ROM read latency in clocks (1..4)
//   TERM     8'h00  terminator byte value
//   ADDR_W   (localparam) = SEL_W+SLOT_W
//
// PORTS
//   clk_i        in   1        system clock
//   rst_i        in   1        synchronous reset, active high
//   restart_i    in   1        start request; honoured only in IDLE
//   msg_sel_i    in   SEL_W    slot index, sampled with accepted restart_i
//   rom_data_i   in   8        ROM read data, valid ROM_LAT clocks after rom_addr_o
//   uart_busy_i  in   1        UART transmitter busy
//   rom_addr_o   out  ADDR_W   ROM address = {slot, offset}
//   tx_data_o    out  8        byte presented to the UART, registered
//   tx_start_o   out  1        UART start request
//   busy_o       out  1        high in every state except IDLE
//   done_o       out  1        one-clock pulse when a message completes
//   overflow_o   out  1        sticky; slot ended without terminator; cleared by accepted restart
//
// BEHAVIOUR
//   - Reset (rst_i=1 at clk edge): state IDLE. All outputs 0. Slot and offset 0. rst_i has priority over all inputs.
//   - States: IDLE, FETCH, CHECK, START_TX, TX, NEXT (+ CR, LF with CRLF_EN).
//   - IDLE: restart_i=1 -> latch msg_sel_i, offset<=0, overflow_o<=0, go to FETCH.
//     restart_i outside IDLE is ignored.
//   - FETCH: wait ROM_LAT clocks (internal counter), then go to CHECK.
//   - CHECK: rom_data_i==TERM -> end of message. Otherwise tx_data_o<=rom_data_i, go to START_TX.
//   - START_TX: tx_start_o=1 while uart_busy_i=0. On the first clock with uart_busy_i=1:
//     tx_start_o<=0, go to TX. tx_data_o is stable from entry to TX exit.
//   - TX: wait for uart_busy_i=0, then go to NEXT.
//   - NEXT: offset==2**SLOT_W-1 -> overflow_o<=1 and end of message (the offset does
//     not wrap into the next slot). Otherwise offset<=offset+1, go to FETCH.
//   - End of message: done_o pulses 1 clock on the transition into IDLE.
//   - Latency: from accepted restart to tx_start_o=1 is ROM_LAT+2 clocks.
//   - Empty message (first byte==TERM): no tx_start_o; done_o pulses; overflow_o stays 0.
//   - uart_busy_i already high on entry to START_TX: tx_start_o is never raised;
//     the block waits for busy low, then raises tx_start_o.
//   - rst_i mid-transfer: abort immediately with no done_o pulse; tx_start_o drops the same edge.
//
// CONFIGURATION
//   CRLF_EN defined: end of message passes through states CR then LF. Each sends
//     8'h0D / 8'h0A using the same START_TX/TX handshake, then goes to IDLE and
//     pulses done_o. This also applies on overflow.
//   CRLF_EN undefined: end of message goes straight to IDLE. The CR/LF states and
//     their logic are not synthesised.
//
// TESTING
//   1. Slot 1 = "HI",00; msg_sel_i=1; pulse restart_i -> addresses 0x10,0x11,0x12;
//      UART receives 'H','I'; one done_o; overflow_o=0.
//   2. Slot 0 first byte 00 -> no tx_start_o; done_o 1 clock after CHECK; busy_o low afterwards.
//   3. Slot 2 with 16 non-zero bytes -> 16 bytes sent; addr stops at 0x2F;
//      overflow_o=1 until next restart.
//   4. restart_i pulsed during TX of byte 0 -> ignored; message completes unchanged; single done_o.
//   5. rst_i asserted in TX -> next edge: IDLE, tx_start_o=0, busy_o=0, no done_o.
//      A later restart works normally.
//   6. CRLF_EN, ROM_LAT=2, slot 3 = "A",00 -> UART receives 41,0D,0A; first tx_start_o
//      4 clocks after restart.

Source files
------------

// File: rtl/msg_sequencer_if.sv
// Bus between msg_sequencer and its ROM / UART neighbours.
//   rom_addr  : ROM read address {slot, offset}, driven by the sequencer
//   rom_data  : ROM read data, returned ROM_LAT clocks after rom_addr
//   tx_data   : byte presented to the UART transmitter (registered)
//   tx_start  : UART start request (registered)
//   uart_busy : UART transmitter busy
// master = sequencer side, slave = ROM/UART side.
interface msg_sequencer_if #(
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              uart_busy;

  modport master (
    output rom_addr, tx_data, tx_start,
    input  rom_data, uart_busy
  );

  modport slave (
    input  rom_addr, tx_data, tx_start,
    output rom_data, uart_busy
  );
endinterface

// File: rtl/msg_sequencer.sv
// ROM-to-UART message sequencer.
// On an accepted restart it selects one of 2**SEL_W message slots in a
// synchronous ROM and walks it byte by byte, handing each byte to the UART
// with a start/busy handshake. It stops at the TERM byte or at the last
// byte of the slot (the latter raises the sticky overflow flag).
//
// Optional feature macro: CRLF_EN. When defined, every message end (including
// overflow) is followed by CR (8'h0D) and LF (8'h0A) through the same
// handshake before returning to IDLE. When undefined those states and their
// logic are not built.
//
// Ports:
//   clk_i       system clock
//   rst_i       synchronous reset, active high
//   restart_i   start request, honoured only in IDLE
//   msg_sel_i   slot index, captured with an accepted restart
//   busy_o      high in every state except IDLE
//   done_o      one-clock pulse on the transition back into IDLE
//   overflow_o  sticky: slot ended without terminator; cleared by restart
//   bus         msg_sequencer_if.master (ROM address/data, UART handshake)
module msg_sequencer #(
  parameter int         SEL_W   = 2,
  parameter int         SLOT_W  = 4,
  parameter int         ROM_LAT = 1,
  parameter logic [7:0] TERM    = 8'h00
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             restart_i,
  input  logic [SEL_W-1:0] msg_sel_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             overflow_o,
  msg_sequencer_if.master  bus
);

  localparam int ADDR_W = SEL_W + SLOT_W;
  localparam logic [SLOT_W-1:0] OFS_LAST = '1;
  // FETCH lasts ROM_LAT clocks; the counter runs 0..ROM_LAT-1.
  localparam logic [1:0] LAT_LAST = 2'(ROM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_CHECK    = 3'd2,
    S_START_TX = 3'd3,
    S_TX       = 3'd4,
    S_NEXT     = 3'd5
`ifdef CRLF_EN
    ,
    S_CR       = 3'd6,
    S_LF       = 3'd7
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  slot_q, slot_d;
  logic [SLOT_W-1:0] offset_q, offset_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;
  state_t            end_state;

`ifdef CRLF_EN
  // Which byte the shared START_TX/TX handshake is carrying, so TX knows
  // where to go once the UART is free again.
  typedef enum logic [1:0] {
    P_DATA = 2'd0,
    P_CR   = 2'd1,
    P_LF   = 2'd2
  } phase_t;

  phase_t phase_q, phase_d;

  assign end_state = S_CR;
`else
  assign end_state = S_IDLE;
`endif

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      slot_q     <= '0;
      offset_q   <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
`ifdef CRLF_EN
      phase_q    <= P_DATA;
`endif
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      offset_q   <= offset_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
`ifdef CRLF_EN
      phase_q    <= phase_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (restart_i) state_d = S_FETCH;
      S_FETCH:    if (cnt_q == LAT_LAST) state_d = S_CHECK;
      S_CHECK:    state_d = (bus.rom_data == TERM) ? end_state : S_START_TX;
      // Leave only once our own start has been acknowledged by busy.
      S_START_TX: if (tx_start_q && bus.uart_busy) state_d = S_TX;
      S_TX: begin
        if (!bus.uart_busy) begin
`ifdef CRLF_EN
          case (phase_q)
            P_CR:    state_d = S_LF;
            P_LF:    state_d = S_IDLE;
            default: state_d = S_NEXT;
          endcase
`else
          state_d = S_NEXT;
`endif
        end
      end
      S_NEXT:     state_d = (offset_q == OFS_LAST) ? end_state : S_FETCH;
`ifdef CRLF_EN
      S_CR:       state_d = S_START_TX;
      S_LF:       state_d = S_START_TX;
`endif
      default:    state_d = S_IDLE;
    endcase
  end

  // Output and datapath logic
  always_comb begin
    slot_d     = slot_q;
    offset_d   = offset_q;
    cnt_d      = '0;
    tx_data_d  = tx_data_q;
    tx_start_d = tx_start_q;
    overflow_d = overflow_q;
`ifdef CRLF_EN
    phase_d    = phase_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (restart_i) begin
          slot_d     = msg_sel_i;
          offset_d   = '0;
          overflow_d = 1'b0;
`ifdef CRLF_EN
          phase_d    = P_DATA;
`endif
        end
      end
      S_FETCH: cnt_d = cnt_q + 2'd1;
      S_CHECK: if (bus.rom_data != TERM) tx_data_d = bus.rom_data;
      S_START_TX: begin
        // A UART that is already busy on entry must drop first; start is
        // raised only while it is idle and withdrawn once it goes busy.
        if (!tx_start_q) tx_start_d = !bus.uart_busy;
        else if (bus.uart_busy) tx_start_d = 1'b0;
      end
      S_NEXT: begin
        // The offset stops at the last byte of the slot instead of wrapping.
        if (offset_q == OFS_LAST) overflow_d = 1'b1;
        else offset_d = offset_q + 1'b1;
      end
`ifdef CRLF_EN
      S_CR: begin
        tx_data_d = 8'h0D;
        phase_d   = P_CR;
      end
      S_LF: begin
        tx_data_d = 8'h0A;
        phase_d   = P_LF;
      end
`endif
      default: ;
    endcase
    done_d = (state_d == S_IDLE) && (state_q != S_IDLE);
  end

  assign bus.rom_addr = {slot_q, offset_q};
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = done_q;
  assign overflow_o   = overflow_q;

endmodule
